// File: rtl/self_output_sched_if.sv
// self_output_sched_if
//   Handshake and pulse signals between the self-output sequencer and the
//   three resources it drives.
//   dma_cmd_valid/ready      : DMA command handshake
//   dma_cmd_addr/len/wr/buf  : command fields (DDR byte address, byte count,
//                              direction 1 = write, on-chip buffer select)
//   dma_done/dma_err         : one-cycle DMA completion / error pulses
//   mm_start/mm_tile/mm_done : matmul tile launch, tile index, completion
//   ln_start/ln_done         : layernorm launch and completion
//   master = sequencer side, slave = engine side.
interface self_output_sched_if;
   logic        dma_cmd_valid;
   logic        dma_cmd_ready;
   logic [63:0] dma_cmd_addr;
   logic [31:0] dma_cmd_len;
   logic        dma_cmd_wr;
   logic [1:0]  dma_cmd_buf;
   logic        dma_done;
   logic        dma_err;
   logic        mm_start;
   logic [7:0]  mm_tile;
   logic        mm_done;
   logic        ln_start;
   logic        ln_done;

   modport master (
      output dma_cmd_valid, dma_cmd_addr, dma_cmd_len, dma_cmd_wr, dma_cmd_buf,
      output mm_start, mm_tile, ln_start,
      input  dma_cmd_ready, dma_done, dma_err, mm_done, ln_done
   );

   modport slave (
      input  dma_cmd_valid, dma_cmd_addr, dma_cmd_len, dma_cmd_wr, dma_cmd_buf,
      input  mm_start, mm_tile, ln_start,
      output dma_cmd_ready, dma_done, dma_err, mm_done, ln_done
   );
endinterface

// File: rtl/self_output_sched.sv
// self_output_sched
//   Top-level sequencer for the self-output layer:
//   LayerNorm(attention_output x W_self_output + bias + residual).
//   Loads activations and residual, streams the weight matrix through the
//   matmul engine one column tile at a time, runs layernorm, then stores the
//   result to DDR.
// Ports
//   clk, rstn_pl          : clock, asynchronous active-low reset
//   start                 : run request, rising-edge detected
//   done, error           : sticky run status
//   addr_*                : DDR byte addresses (latched at launch)
//   requant_*             : requant values (latched at launch, driven on cfg_*)
//   cfg_*                 : latched requant values for the engines
//   bus                   : DMA / matmul / layernorm handshakes (master side)
module self_output_sched #(
   parameter int unsigned TOKENS  = 32,
   parameter int unsigned EMBED   = 768,
   parameter int unsigned TILE_N  = 64,
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic                       clk,
   input  logic                       rstn_pl,
   input  logic                       start,
   output logic                       done,
   output logic                       error,
   input  logic [63:0]                addr_attn_output,
   input  logic [63:0]                addr_weight,
   input  logic [63:0]                addr_residual,
   input  logic [63:0]                addr_output,
   input  logic [31:0]                requant_m_mm,
   input  logic [7:0]                 requant_e_mm,
   input  logic [31:0]                requant_m_ln,
   input  logic [7:0]                 requant_e_ln,
   output logic [31:0]                cfg_m_mm,
   output logic [7:0]                 cfg_e_mm,
   output logic [31:0]                cfg_m_ln,
   output logic [7:0]                 cfg_e_ln,
   self_output_sched_if.master        bus
);

   localparam int unsigned NT        = EMBED / TILE_N;
   localparam logic [31:0] ACT_LEN   = 32'(TOKENS * EMBED);
   localparam logic [31:0] WT_LEN    = 32'(EMBED * TILE_N);
   localparam logic [63:0] WT_STRIDE = 64'(EMBED * TILE_N);
   localparam logic [7:0]  LAST_TILE = 8'(NT - 1);
   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

   localparam logic [3:0] StIdle   = 4'd0;
   localparam logic [3:0] StLdAct  = 4'd1;
   localparam logic [3:0] StWtAct  = 4'd2;
   localparam logic [3:0] StLdRes  = 4'd3;
   localparam logic [3:0] StWtRes  = 4'd4;
   localparam logic [3:0] StLdW    = 4'd5;
   localparam logic [3:0] StWtW    = 4'd6;
   localparam logic [3:0] StMm     = 4'd7;
   localparam logic [3:0] StMmWait = 4'd8;
   localparam logic [3:0] StLn     = 4'd9;
   localparam logic [3:0] StLnWait = 4'd10;
   localparam logic [3:0] StStOut  = 4'd11;
   localparam logic [3:0] StWtOut  = 4'd12;
   localparam logic [3:0] StDone   = 4'd13;
   localparam logic [3:0] StErr    = 4'd14;

   logic [3:0]  state_q, state_d;
   logic [7:0]  tile_q, tile_d;
   logic [31:0] tmo_q, tmo_d;
   logic        start_q;
   logic        launch, accept, waiting, tmo_hit;

   logic [63:0] attn_q, attn_d, wt_q, wt_d, res_q, res_d, out_q, out_d;
   logic [31:0] m_mm_q, m_mm_d, m_ln_q, m_ln_d;
   logic [7:0]  e_mm_q, e_mm_d, e_ln_q, e_ln_d;

   logic        cmd_valid_q, cmd_valid_d;
   logic [63:0] cmd_addr_q, cmd_addr_d;
   logic [31:0] cmd_len_q, cmd_len_d;
   logic        cmd_wr_q, cmd_wr_d;
   logic [1:0]  cmd_buf_q, cmd_buf_d;
   logic        mm_start_q, mm_start_d;
   logic [7:0]  mm_tile_q, mm_tile_d;
   logic        ln_start_q, ln_start_d;
   logic        done_q, done_d;
   logic        error_q, error_d;

   assign launch  = start & ~start_q &
                    ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
   assign accept  = cmd_valid_q & bus.dma_cmd_ready;
   assign tmo_hit = (tmo_q == TMO_LAST);

   // Every state that sits waiting on an external event is covered by the timeout,
   // including command states stalled on dma_cmd_ready.
   always_comb begin
      case (state_q)
         StLdAct, StWtAct, StLdRes, StWtRes, StLdW, StWtW,
         StMmWait, StLnWait, StStOut, StWtOut: waiting = 1'b1;
         default:                              waiting = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      tile_d  = tile_q;
      case (state_q)
         StIdle, StDone, StErr: begin
            if (launch) begin
               state_d = StLdAct;
               tile_d  = '0;
            end
         end
         StLdAct: if (accept) state_d = StWtAct;
         StLdRes: if (accept) state_d = StWtRes;
         StLdW:   if (accept) state_d = StWtW;
         StStOut: if (accept) state_d = StWtOut;
         // Error wins over a simultaneous done.
         StWtAct: begin
            if (bus.dma_err)       state_d = StErr;
            else if (bus.dma_done) state_d = StLdRes;
         end
         StWtRes: begin
            if (bus.dma_err)       state_d = StErr;
            else if (bus.dma_done) state_d = StLdW;
         end
         StWtW: begin
            if (bus.dma_err)       state_d = StErr;
            else if (bus.dma_done) state_d = StMm;
         end
         StWtOut: begin
            if (bus.dma_err)       state_d = StErr;
            else if (bus.dma_done) state_d = StDone;
         end
         StMm: state_d = StMmWait;
         StMmWait: begin
            if (bus.mm_done) begin
               if (tile_q == LAST_TILE) begin
                  state_d = StLn;
               end else begin
                  tile_d  = tile_q + 8'd1;
                  state_d = StLdW;
               end
            end
         end
         StLn:     state_d = StLnWait;
         StLnWait: if (bus.ln_done) state_d = StStOut;
         default:  state_d = StIdle;
      endcase
      // Still waiting on the last allowed cycle: abort.
      if (waiting && (state_d == state_q) && tmo_hit) state_d = StErr;
   end

   // Counter is zero on the first cycle of each waiting state.
   assign tmo_d = (waiting && (state_d == state_q)) ? tmo_q + 32'd1 : '0;

   always_comb begin
      attn_d = attn_q;
      wt_d   = wt_q;
      res_d  = res_q;
      out_d  = out_q;
      m_mm_d = m_mm_q;
      e_mm_d = e_mm_q;
      m_ln_d = m_ln_q;
      e_ln_d = e_ln_q;
      if (launch) begin
         attn_d = addr_attn_output;
         wt_d   = addr_weight;
         res_d  = addr_residual;
         out_d  = addr_output;
         m_mm_d = requant_m_mm;
         e_mm_d = requant_e_mm;
         m_ln_d = requant_m_ln;
         e_ln_d = requant_e_ln;
      end
   end

   // Outputs are registered copies of what the next state wants, so they line up
   // with the state they belong to.
   always_comb begin
      cmd_valid_d = 1'b0;
      cmd_addr_d  = cmd_addr_q;
      cmd_len_d   = cmd_len_q;
      cmd_wr_d    = cmd_wr_q;
      cmd_buf_d   = cmd_buf_q;
      case (state_d)
         StLdAct: begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = attn_d;
            cmd_len_d   = ACT_LEN;
            cmd_wr_d    = 1'b0;
            cmd_buf_d   = 2'd0;
         end
         StLdRes: begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = res_d;
            cmd_len_d   = ACT_LEN;
            cmd_wr_d    = 1'b0;
            cmd_buf_d   = 2'd1;
         end
         StLdW: begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = wt_d + 64'(tile_d) * WT_STRIDE;
            cmd_len_d   = WT_LEN;
            cmd_wr_d    = 1'b0;
            cmd_buf_d   = 2'd2;
         end
         StStOut: begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = out_d;
            cmd_len_d   = ACT_LEN;
            cmd_wr_d    = 1'b1;
            cmd_buf_d   = 2'd3;
         end
         default: ;
      endcase
      mm_start_d = (state_d == StMm);
      mm_tile_d  = mm_start_d ? tile_d : mm_tile_q;
      ln_start_d = (state_d == StLn);
      done_d     = (state_d == StDone);
      error_d    = (state_d == StErr);
   end

   always_ff @(posedge clk or negedge rstn_pl) begin
      if (!rstn_pl) begin
         state_q     <= StIdle;
         tile_q      <= '0;
         tmo_q       <= '0;
         start_q     <= 1'b0;
         attn_q      <= '0;
         wt_q        <= '0;
         res_q       <= '0;
         out_q       <= '0;
         m_mm_q      <= '0;
         e_mm_q      <= '0;
         m_ln_q      <= '0;
         e_ln_q      <= '0;
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
         cmd_wr_q    <= 1'b0;
         cmd_buf_q   <= '0;
         mm_start_q  <= 1'b0;
         mm_tile_q   <= '0;
         ln_start_q  <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tile_q      <= tile_d;
         tmo_q       <= tmo_d;
         start_q     <= start;
         attn_q      <= attn_d;
         wt_q        <= wt_d;
         res_q       <= res_d;
         out_q       <= out_d;
         m_mm_q      <= m_mm_d;
         e_mm_q      <= e_mm_d;
         m_ln_q      <= m_ln_d;
         e_ln_q      <= e_ln_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_len_q   <= cmd_len_d;
         cmd_wr_q    <= cmd_wr_d;
         cmd_buf_q   <= cmd_buf_d;
         mm_start_q  <= mm_start_d;
         mm_tile_q   <= mm_tile_d;
         ln_start_q  <= ln_start_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign done              = done_q;
   assign error             = error_q;
   assign cfg_m_mm          = m_mm_q;
   assign cfg_e_mm          = e_mm_q;
   assign cfg_m_ln          = m_ln_q;
   assign cfg_e_ln          = e_ln_q;
   assign bus.dma_cmd_valid = cmd_valid_q;
   assign bus.dma_cmd_addr  = cmd_addr_q;
   assign bus.dma_cmd_len   = cmd_len_q;
   assign bus.dma_cmd_wr    = cmd_wr_q;
   assign bus.dma_cmd_buf   = cmd_buf_q;
   assign bus.mm_start      = mm_start_q;
   assign bus.mm_tile       = mm_tile_q;
   assign bus.ln_start      = ln_start_q;

endmodule
